// File: rtl/hps_restart_pkg.sv
// Shared state encoding and status-word bit layout for the HPS restart responder.
// The bit positions mirror the HPS software header that decodes the status PIO.
package hps_restart_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        DRAIN   = 2'd1,
        RESTART = 2'd2,
        DONE    = 2'd3
    } state_e;

    localparam int ST_LSB   = 0;
    localparam int ST_MSB   = 1;
    localparam int HOLD_BIT = 2;
    localparam int TO_BIT   = 3;
    localparam int CNT_LSB  = 4;
    localparam int CNT_MSB  = 7;

    localparam logic [3:0] CNT_MAX = 4'hF;

endpackage

// File: rtl/hps_restart_responder_if.sv
// Handshake/status bundle between the HPS PIO block, the responder and the
// firewall datapath.
interface hps_restart_responder_if;

    logic       restart_req;
    logic       fw_busy;
    logic       fw_hold;
    logic       fw_restart;
    logic [7:0] hps_status_export;

    modport master (
        output restart_req,
        output fw_busy,
        input  fw_hold,
        input  fw_restart,
        input  hps_status_export
    );

    modport slave (
        input  restart_req,
        input  fw_busy,
        output fw_hold,
        output fw_restart,
        output hps_status_export
    );

endinterface

// File: rtl/hps_cycle_counter.sv
// Loadable down-counter; tc_o flags the last counted cycle (count == 1).
module hps_cycle_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load_i,
    input  logic [W-1:0] val_i,
    input  logic         en_i,
    output logic         tc_o
);

    logic [W-1:0] cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (load_i) begin
            cnt_q <= val_i;
        end else if (en_i && cnt_q != '0) begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

    assign tc_o = (cnt_q == W'(1));

endmodule

// File: rtl/hps_restart_responder.sv
// HPS-driven drain/restart sequencer for the firewall datapath.
// Define HPS_RESTART_TIMEOUT_EN to bound the DRAIN phase by DRAIN_TIMEOUT.
import hps_restart_pkg::*;

module hps_restart_responder #(
    parameter int unsigned DRAIN_TIMEOUT  = 1024,
    parameter int unsigned RESTART_CYCLES = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    hps_restart_responder_if.slave   bus
);

`ifdef HPS_RESTART_TIMEOUT_EN
    localparam int CW = 16;
`else
    localparam int CW = 8;
`endif
    localparam logic [CW-1:0] RC_LD = CW'(RESTART_CYCLES);

    if (RESTART_CYCLES < 1 || RESTART_CYCLES > 255 ||
        DRAIN_TIMEOUT < 2 || DRAIN_TIMEOUT > 65535) begin : g_bad_param
        $error("hps_restart_responder: parameter out of range");
    end

    state_e      state_q;
    logic        hold_q;
    logic        fire_q;
    logic [3:0]  cnt_q;
    logic        req_q;
    logic        armed_q;
    logic        to_q;
    logic        rise;
    logic        drain_exit;
    logic        tc_w;
    logic        ld_w;
    logic        en_w;
    logic [CW-1:0] ld_val_w;
    logic [7:0]  status_w;

    // armed_q masks the first sample after reset so a held request is not an edge
    assign rise = armed_q & bus.restart_req & ~req_q;

`ifdef HPS_RESTART_TIMEOUT_EN
    localparam logic [CW-1:0] DT_LD = CW'(DRAIN_TIMEOUT);
    assign drain_exit = ~bus.fw_busy | tc_w;
    assign ld_w       = (state_q == IDLE && rise) ||
                        (state_q == DRAIN && drain_exit);
    assign ld_val_w   = (state_q == IDLE) ? DT_LD : RC_LD;
    assign en_w       = (state_q == DRAIN) || (state_q == RESTART);
`else
    assign drain_exit = ~bus.fw_busy;
    assign ld_w       = (state_q == DRAIN) && drain_exit;
    assign ld_val_w   = RC_LD;
    assign en_w       = (state_q == RESTART);
    assign to_q       = 1'b0;
`endif

    hps_cycle_counter #(.W(CW)) u_cnt (
        .clk    (clk),
        .rst    (reset),
        .load_i (ld_w),
        .val_i  (ld_val_w),
        .en_i   (en_w),
        .tc_o   (tc_w)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            hold_q  <= 1'b0;
            fire_q  <= 1'b0;
            cnt_q   <= 4'd0;
            req_q   <= 1'b0;
            armed_q <= 1'b0;
`ifdef HPS_RESTART_TIMEOUT_EN
            to_q    <= 1'b0;
`endif
        end else begin
            req_q   <= bus.restart_req;
            armed_q <= 1'b1;
            unique case (state_q)
                IDLE: begin
                    if (rise) begin
                        state_q <= DRAIN;
                        hold_q  <= 1'b1;
`ifdef HPS_RESTART_TIMEOUT_EN
                        to_q    <= 1'b0;
`endif
                    end
                end
                DRAIN: begin
                    if (drain_exit) begin
                        state_q <= RESTART;
                        fire_q  <= 1'b1;
`ifdef HPS_RESTART_TIMEOUT_EN
                        if (bus.fw_busy) to_q <= 1'b1;
`endif
                    end
                end
                RESTART: begin
                    if (tc_w) begin
                        state_q <= DONE;
                        fire_q  <= 1'b0;
                        if (cnt_q != CNT_MAX) cnt_q <= cnt_q + 4'd1;
                    end
                end
                DONE: begin
                    if (!bus.restart_req) begin
                        state_q <= IDLE;
                        hold_q  <= 1'b0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    always_comb begin
        status_w                  = '0;
        status_w[ST_MSB:ST_LSB]   = state_q;
        status_w[HOLD_BIT]        = hold_q;
        status_w[TO_BIT]          = to_q;
        status_w[CNT_MSB:CNT_LSB] = cnt_q;
    end

    assign bus.fw_hold           = hold_q;
    assign bus.fw_restart        = fire_q;
    assign bus.hps_status_export = status_w;

endmodule

// File: tb/tb_hps_restart_responder.sv
// Directed bench for hps_restart_responder (DRAIN_TIMEOUT=8, RESTART_CYCLES=16).
module tb_hps_restart_responder;

    logic clk;
    logic reset;
    int   checks;
    int   errors;
    int   n;

`ifdef HPS_RESTART_TIMEOUT_EN
    localparam int BUSY_N = 5;
    localparam logic TOB = 1'b1;
`else
    localparam int BUSY_N = 50;
    localparam logic TOB = 1'b0;
`endif

    hps_restart_responder_if bus ();

    hps_restart_responder #(
        .DRAIN_TIMEOUT  (8),
        .RESTART_CYCLES (16)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_fire(output int cyc);
        cyc = 0;
        while (bus.fw_restart === 1'b1 && cyc < 300) begin
            cyc++;
            tick();
        end
    endtask

    task automatic run_seq();
        int c;
        bus.restart_req = 1'b1;
        tick();
        bus.restart_req = 1'b0;
        tick();
        wait_fire(c);
        tick();
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset  = 1'b1;
        bus.restart_req = 1'b0;
        bus.fw_busy     = 1'b0;
        tick();
        tick();
        check("rst_status", bus.hps_status_export, 8'h00);
        check("rst_hold", bus.fw_hold, 0);
        check("rst_fire", bus.fw_restart, 0);
        reset = 1'b0;
        tick();
        check("idle", bus.hps_status_export, 8'h00);

        // single pulse, datapath idle
        bus.restart_req = 1'b1;
        tick();
        check("drain1", bus.hps_status_export, 8'h05);
        bus.restart_req = 1'b0;
        tick();
        check("restart_entry", bus.hps_status_export, 8'h06);
        wait_fire(n);
        check("fire_len", n, 16);
        check("done1", bus.hps_status_export, 8'h17);
        tick();
        check("idle1", bus.hps_status_export, 8'h10);

        // busy drain, request level held through DONE
        bus.fw_busy     = 1'b1;
        bus.restart_req = 1'b1;
        tick();
        check("drain2", bus.hps_status_export, 8'h15);
        n = 0;
        while (bus.hps_status_export[1:0] == 2'd1 && n < 200) begin
            n++;
            if (n == BUSY_N) bus.fw_busy = 1'b0;
            tick();
        end
        check("drain_len", n, BUSY_N);
        check("restart2", bus.hps_status_export, 8'h16);
        wait_fire(n);
        check("fire_len2", n, 16);
        check("done2", bus.hps_status_export, 8'h27);
        tick();
        check("done2_held", bus.hps_status_export, 8'h27);
        bus.restart_req = 1'b0;
        tick();
        check("idle2", bus.hps_status_export, 8'h20);

        // busy stuck high
        bus.fw_busy     = 1'b1;
        bus.restart_req = 1'b1;
        tick();
        check("drain3", bus.hps_status_export, 8'h25);
`ifdef HPS_RESTART_TIMEOUT_EN
        n = 0;
        while (bus.hps_status_export[1:0] == 2'd1 && n < 400) begin
            n++;
            tick();
        end
        check("timeout_len", n, 8);
        check("timeout_status", bus.hps_status_export, 8'h2E);
        bus.fw_busy = 1'b0;
`else
        repeat (300) tick();
        check("drain_stuck", bus.hps_status_export, 8'h25);
        bus.fw_busy = 1'b0;
        tick();
        check("restart3", bus.hps_status_export, 8'h26);
`endif
        wait_fire(n);
        check("done3", bus.hps_status_export, {4'd3, TOB, 1'b1, 2'd3});
        bus.restart_req = 1'b0;
        tick();
        check("idle3_sticky", bus.hps_status_export, {4'd3, TOB, 1'b0, 2'd0});

        // new request clears flag; extra edge during RESTART ignored
        bus.restart_req = 1'b1;
        tick();
        check("drain4", bus.hps_status_export, 8'h35);
        bus.restart_req = 1'b0;
        tick();
        tick();
        tick();
        bus.restart_req = 1'b1;
        tick();
        bus.restart_req = 1'b0;
        wait_fire(n);
        check("fire_rest4", n, 13);
        check("done4", bus.hps_status_export, 8'h47);
        tick();
        repeat (5) tick();
        check("idle4", bus.hps_status_export, 8'h40);

        // saturation after 17 sequences
        repeat (13) run_seq();
        check("count_sat", bus.hps_status_export, 8'hF0);

        // reset mid-RESTART with request held
        bus.restart_req = 1'b1;
        tick();
        check("drain5", bus.hps_status_export, 8'hF5);
        tick();
        check("restart5", bus.hps_status_export, 8'hF6);
        tick();
        tick();
        reset = 1'b1;
        #1;
        check("async_status", bus.hps_status_export, 8'h00);
        check("async_fire", bus.fw_restart, 0);
        check("async_hold", bus.fw_hold, 0);
        tick();
        tick();
        reset = 1'b0;
        repeat (5) tick();
        check("no_retrigger", bus.hps_status_export, 8'h00);
        bus.restart_req = 1'b0;
        tick();
        bus.restart_req = 1'b1;
        tick();
        check("rearm", bus.hps_status_export, 8'h05);
        bus.restart_req = 1'b0;
        tick();
        wait_fire(n);
        check("fire_len6", n, 16);
        check("done6", bus.hps_status_export, 8'h17);
        tick();
        check("idle6", bus.hps_status_export, 8'h10);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
